enemy_scheduler: RTL and testbench

Slot controller for the pool of enemy instances in the game display pipeline. It decides when each enemyMaster slot is live by driving its `enemyPresent`, and spawns enemies on a frame-counted timer using round-robin slot choice. It retires slots on collision through a timed dying phase, counts kills for the score logic, and merges the per-slot enemy pixel streams into one 6-bit colour for the VGA mixer.

---
 rtl/enemy_scheduler.sv | 161 ++++++++++++++++
 tb/tb_enemy_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_scheduler.sv
// Enemy slot controller: timed round-robin spawning, collision retirement through a
// frame-counted dying phase, saturating kill count and priority merge of slot pixels.
module enemy_scheduler #(
   parameter int unsigned N_SLOTS      = 4,
   parameter int unsigned SPAWN_FRAMES = 60,
   parameter int unsigned DEAD_FRAMES  = 30
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   gameActive,
   input  logic                   frameTick,
   input  logic [N_SLOTS-1:0]     collisionFlag,
   input  logic [6*N_SLOTS-1:0]   rgbContentEnemy,
   output logic [N_SLOTS-1:0]     enemyPresent,
   output logic [5:0]             rgbEnemy,
   output logic [7:0]             killCount,
   output logic                   killPulse,
   output logic                   slotsFull
);

   localparam int unsigned DW = (DEAD_FRAMES > 0) ? $clog2(DEAD_FRAMES + 1) : 1;
   localparam int unsigned SW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
   localparam int unsigned PW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

   typedef enum logic [1:0] {
      FREE  = 2'd0,
      ALIVE = 2'd1,
      DYING = 2'd2
   } slot_st_e;

   slot_st_e        state_q [N_SLOTS];
   logic [DW-1:0]   dcnt_q  [N_SLOTS];
   logic [SW-1:0]   spawn_q;
   logic [PW-1:0]   rr_q;
   logic [7:0]      kill_q, kill_d;
   logic            kpulse_q;
   logic [5:0]      rgb_q, rgb_d;

   logic [N_SLOTS-1:0] alive, free, hits;
   logic [3:0]         pop;
   logic [PW-1:0]      grant_idx;
   logic               spawn_ev;
   logic               found;
   int unsigned        j;

   always_comb begin
      alive = '0;
      free  = '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         alive[i] = (state_q[i] == ALIVE);
         free[i]  = (state_q[i] == FREE);
      end
   end

   assign hits = alive & collisionFlag;

   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         pop = pop + 4'(hits[i]);
      end
   end

   always_comb begin
      logic [8:0] sum;
      sum    = {1'b0, kill_q} + 9'(pop);
      kill_d = sum[8] ? 8'hFF : sum[7:0];
   end

   // First FREE slot at or above rr_q, wrapping to slot 0.
   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      for (int unsigned k = 0; k < N_SLOTS; k++) begin
         j = 32'(rr_q) + k;
         if (j >= N_SLOTS) j = j - N_SLOTS;
         if (!found && free[j]) begin
            found     = 1'b1;
            grant_idx = PW'(j);
         end
      end
   end

   assign spawn_ev = gameActive && frameTick && (spawn_q == SW'(SPAWN_FRAMES - 1)) && (|free);

   always_comb begin
      logic hit;
      rgb_d = '0;
      hit   = 1'b0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         if (!hit && alive[i] && (rgbContentEnemy[6*i +: 6] != 6'h00)) begin
            hit   = 1'b1;
            rgb_d = rgbContentEnemy[6*i +: 6];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < N_SLOTS; i++) begin
            state_q[i] <= FREE;
            dcnt_q[i]  <= '0;
         end
         spawn_q  <= '0;
         rr_q     <= '0;
         kill_q   <= '0;
         kpulse_q <= 1'b0;
         rgb_q    <= '0;
      end else begin
         // Kills are counted even on the cycle gameActive drops and clears the slots.
         kill_q   <= kill_d;
         kpulse_q <= |hits;
         rgb_q    <= rgb_d;
         if (!gameActive) begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
               state_q[i] <= FREE;
               dcnt_q[i]  <= '0;
            end
            spawn_q <= '0;
            rr_q    <= '0;
         end else begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
               case (state_q[i])
                  FREE: begin
                     if (spawn_ev && (grant_idx == PW'(i))) state_q[i] <= ALIVE;
                  end
                  ALIVE: begin
                     if (collisionFlag[i]) begin
                        state_q[i] <= DYING;
                        dcnt_q[i]  <= '0;
                     end
                  end
                  DYING: begin
                     if (frameTick) begin
                        if (dcnt_q[i] == DW'(DEAD_FRAMES - 1)) state_q[i] <= FREE;
                        else dcnt_q[i] <= dcnt_q[i] + DW'(1);
                     end
                  end
                  default: state_q[i] <= FREE;
               endcase
            end
            if (frameTick) begin
               if (spawn_q != SW'(SPAWN_FRAMES - 1)) begin
                  spawn_q <= spawn_q + SW'(1);
               end else if (spawn_ev) begin
                  spawn_q <= '0;
                  rr_q    <= (grant_idx == PW'(N_SLOTS - 1)) ? '0 : grant_idx + PW'(1);
               end
            end
         end
      end
   end

   assign enemyPresent = alive;
   assign slotsFull    = ~|free;
   assign rgbEnemy     = rgb_q;
   assign killCount    = kill_q;
   assign killPulse    = kpulse_q;

endmodule

// File: tb/tb_enemy_scheduler.sv
// Directed bench for enemy_scheduler with N_SLOTS=4, SPAWN_FRAMES=4, DEAD_FRAMES=3.
module tb_enemy_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        gameActive;
   logic        frameTick;
   logic [3:0]  collisionFlag;
   logic [23:0] rgbContentEnemy;
   logic [3:0]  enemyPresent;
   logic [5:0]  rgbEnemy;
   logic [7:0]  killCount;
   logic        killPulse;
   logic        slotsFull;

   int errors = 0;
   int checks = 0;

   enemy_scheduler #(.N_SLOTS(4), .SPAWN_FRAMES(4), .DEAD_FRAMES(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .gameActive      (gameActive),
      .frameTick       (frameTick),
      .collisionFlag   (collisionFlag),
      .rgbContentEnemy (rgbContentEnemy),
      .enemyPresent    (enemyPresent),
      .rgbEnemy        (rgbEnemy),
      .killCount       (killCount),
      .killPulse       (killPulse),
      .slotsFull       (slotsFull)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk) frameTick = 1'b1;
      @(negedge clk) frameTick = 1'b0;
   endtask

   task automatic collide(input logic [3:0] v);
      @(negedge clk) collisionFlag = v;
      @(negedge clk) collisionFlag = 4'b0000;
   endtask

   task automatic wait_present(input logic [3:0] target, input int bound);
      int n;
      n = 0;
      while (enemyPresent !== target && n < bound) begin
         tick();
         n++;
      end
      checks++;
      if (enemyPresent !== target) begin
         errors++;
         $display("FAIL wait_present: enemyPresent=%b required %b within %0d ticks", enemyPresent, target, bound);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      gameActive = 1'b0; frameTick = 1'b0; collisionFlag = '0; rgbContentEnemy = '0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (enemyPresent !== 4'b0000) begin errors++; $display("FAIL reset_present: got %b want 0000", enemyPresent); end
      checks++;
      if (rgbEnemy !== 6'h00) begin errors++; $display("FAIL reset_rgb: got %h want 00", rgbEnemy); end
      checks++;
      if (killCount !== 8'd0 || killPulse !== 1'b0) begin
         errors++; $display("FAIL reset_kill: count=%0d pulse=%b want 0/0", killCount, killPulse);
      end
      checks++;
      if (slotsFull !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", slotsFull); end
      reset = 1'b1;
   endtask

   task automatic test_spawn();
      @(negedge clk) gameActive = 1'b1;
      repeat (3) tick();
      checks++;
      if (enemyPresent !== 4'b0000) begin errors++; $display("FAIL spawn_early: got %b want 0000", enemyPresent); end
      tick();
      checks++;
      if (enemyPresent !== 4'b0001) begin errors++; $display("FAIL spawn_first: got %b want 0001", enemyPresent); end
      repeat (4) tick();
      checks++;
      if (enemyPresent !== 4'b0011 || slotsFull !== 1'b0) begin
         errors++; $display("FAIL spawn_second: present=%b full=%b want 0011/0", enemyPresent, slotsFull);
      end
      repeat (8) tick();
      checks++;
      if (enemyPresent !== 4'b1111 || slotsFull !== 1'b1) begin
         errors++; $display("FAIL spawn_full: present=%b full=%b want 1111/1", enemyPresent, slotsFull);
      end
   endtask

   task automatic test_collision_pending();
      repeat (4) tick();
      checks++;
      if (enemyPresent !== 4'b1111) begin errors++; $display("FAIL pending_hold: got %b want 1111", enemyPresent); end
      collide(4'b0100);
      checks++;
      if (enemyPresent !== 4'b1011 || killCount !== 8'd1 || killPulse !== 1'b1) begin
         errors++; $display("FAIL collide_one: present=%b count=%0d pulse=%b want 1011/1/1", enemyPresent, killCount, killPulse);
      end
      @(negedge clk);
      checks++;
      if (killPulse !== 1'b0 || killCount !== 8'd1) begin
         errors++; $display("FAIL pulse_width: pulse=%b count=%0d want 0/1", killPulse, killCount);
      end
      repeat (2) tick();
      checks++;
      if (enemyPresent !== 4'b1011 || slotsFull !== 1'b1) begin
         errors++; $display("FAIL dying_hold: present=%b full=%b want 1011/1", enemyPresent, slotsFull);
      end
      tick();
      checks++;
      if (enemyPresent !== 4'b1011 || slotsFull !== 1'b0) begin
         errors++; $display("FAIL dying_free: present=%b full=%b want 1011/0", enemyPresent, slotsFull);
      end
      tick();
      checks++;
      if (enemyPresent !== 4'b1111) begin errors++; $display("FAIL pending_spawn: got %b want 1111", enemyPresent); end
   endtask

   task automatic test_saturate();
      for (int r = 0; r < 63; r++) begin
         collide(4'b1111);
         wait_present(4'b1111, 40);
         if (enemyPresent !== 4'b1111) break;
      end
      checks++;
      if (killCount !== 8'd253) begin errors++; $display("FAIL kill_accum: got %0d want 253", killCount); end
      collide(4'b1111);
      checks++;
      if (killCount !== 8'd255 || killPulse !== 1'b1 || enemyPresent !== 4'b0000) begin
         errors++; $display("FAIL kill_saturate: count=%0d pulse=%b present=%b want 255/1/0000", killCount, killPulse, enemyPresent);
      end
   endtask

   task automatic test_merge();
      @(negedge clk) gameActive = 1'b0;
      @(negedge clk) gameActive = 1'b1;
      wait_present(4'b1111, 40);
      collide(4'b0101);
      checks++;
      if (enemyPresent !== 4'b1010 || killCount !== 8'd255 || killPulse !== 1'b1) begin
         errors++; $display("FAIL kill_no_wrap: present=%b count=%0d pulse=%b want 1010/255/1", enemyPresent, killCount, killPulse);
      end
      @(negedge clk) rgbContentEnemy = {6'h2A, 6'h22, 6'h00, 6'h11};
      @(negedge clk);
      checks++;
      if (rgbEnemy !== 6'h2A) begin errors++; $display("FAIL merge_slot3: got %h want 2a", rgbEnemy); end
      rgbContentEnemy = {6'h2A, 6'h22, 6'h15, 6'h11};
      checks++;
      if (rgbEnemy !== 6'h2A) begin errors++; $display("FAIL merge_lag: got %h want 2a", rgbEnemy); end
      @(negedge clk);
      checks++;
      if (rgbEnemy !== 6'h15) begin errors++; $display("FAIL merge_slot1: got %h want 15", rgbEnemy); end
      rgbContentEnemy = {6'h00, 6'h22, 6'h00, 6'h11};
      @(negedge clk);
      checks++;
      if (rgbEnemy !== 6'h00) begin errors++; $display("FAIL merge_none: got %h want 00", rgbEnemy); end
      rgbContentEnemy = '0;
   endtask

   task automatic test_game_inactive();
      int bad;
      do_reset();
      wait_present(4'b1111, 40);
      collide(4'b1111);
      wait_present(4'b0001, 40);
      collide(4'b0001);
      wait_present(4'b1110, 40);
      checks++;
      if (killCount !== 8'd5) begin errors++; $display("FAIL pre_drop_count: got %0d want 5", killCount); end
      @(negedge clk) gameActive = 1'b0;
      @(negedge clk);
      checks++;
      if (enemyPresent !== 4'b0000 || killCount !== 8'd5 || slotsFull !== 1'b0) begin
         errors++; $display("FAIL drop_clear: present=%b count=%0d full=%b want 0000/5/0", enemyPresent, killCount, slotsFull);
      end
      bad = 0;
      repeat (100) begin
         tick();
         if (enemyPresent !== 4'b0000) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL idle_spawn: %0d ticks with enemyPresent nonzero, want 0", bad); end
      @(negedge clk) gameActive = 1'b1;
      repeat (3) tick();
      checks++;
      if (enemyPresent !== 4'b0000 || killCount !== 8'd5) begin
         errors++; $display("FAIL rearm_early: present=%b count=%0d want 0000/5", enemyPresent, killCount);
      end
      tick();
      checks++;
      if (enemyPresent !== 4'b0001) begin errors++; $display("FAIL rearm_spawn: got %b want 0001", enemyPresent); end
      @(negedge clk) begin gameActive = 1'b0; collisionFlag = 4'b0001; end
      @(negedge clk) collisionFlag = 4'b0000;
      checks++;
      if (enemyPresent !== 4'b0000 || killCount !== 8'd6 || killPulse !== 1'b1) begin
         errors++; $display("FAIL drop_with_kill: present=%b count=%0d pulse=%b want 0000/6/1", enemyPresent, killCount, killPulse);
      end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_collision_pending();
      test_saturate();
      test_merge();
      test_game_inactive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
